// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
//
// Serializes mono samples onto a standard I2S link. Each accepted sample is
// duplicated into the left and right slots of one frame. BCLK and LRCLK are
// derived from clk. A single holding register sits behind a valid/ready
// handshake, and at most one sample is consumed per frame.
//
// Optional feature macro: I2S_TX_UNDERRUN_HOLD_EN
//   defined   - on underrun, the previous frame word is repeated
//   undefined - on underrun, silence (0) is sent
//
// Parameters
//   SAMPLE_WIDTH  width of sample, in bits
//   SLOT_BITS     BCLK periods per channel slot (>= SAMPLE_WIDTH)
//   BCLK_HALF     clk cycles per BCLK half-period (>= 2)
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sample        two's-complement input sample
//   sample_valid  sample is valid this cycle
//   sample_ready  holding register is empty (registered)
//   bclk          I2S bit clock
//   lrclk         I2S word select (0 = left, 1 = right)
//   sdata         I2S serial data, MSB first, zero padded after the LSB
//   underrun      one-cycle pulse when a frame starts with no sample held
// -----------------------------------------------------------------------------
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 16,
  parameter int BCLK_HALF    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = $clog2(BCLK_HALF);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int PAD_BITS   = SLOT_BITS - SAMPLE_WIDTH;

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] LR_FIRST  = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] LR_LAST   = BIT_W'(FRAME_BITS - 2);

  // Left-justify a sample inside a slot; bits after the LSB are zero.
  function automatic logic [SLOT_BITS-1:0] slot_align(input logic [SAMPLE_WIDTH-1:0] w);
    return SLOT_BITS'(w) << PAD_BITS;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SLOT_BITS-1:0]    shift_reg;
  logic [SAMPLE_WIDTH-1:0] frame_word;
  logic [SAMPLE_WIDTH-1:0] hold_reg;
  logic                    full;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic                    wrap;
  logic                    fall;
  logic [BIT_W-1:0]        bit_nxt;
  logic                    frame_load;
  logic                    slot_load;
  logic                    transfer;
  logic                    full_nxt;
  logic                    lrclk_nxt;
  logic [SAMPLE_WIDTH-1:0] fill_word;
  logic [SAMPLE_WIDTH-1:0] load_word;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wrap       = (div_cnt == DIV_MAX);
    fall       = wrap & bclk;
    bit_nxt    = (bit_cnt == BIT_MAX) ? '0 : bit_cnt + BIT_W'(1);
    frame_load = fall & (bit_nxt == '0);
    slot_load  = fall & (bit_nxt == BIT_RIGHT);
    transfer   = sample_valid & sample_ready;
    lrclk_nxt  = (bit_nxt >= LR_FIRST) && (bit_nxt <= LR_LAST);

`ifdef I2S_TX_UNDERRUN_HOLD_EN
    fill_word  = frame_word;
`else
    fill_word  = '0;
`endif
    load_word  = full ? hold_reg : fill_word;

    // sample_ready mirrors ~full, so a transfer can only happen while empty.
    // A load that coincides with a transfer leaves the new sample held.
    full_nxt = full;
    if (transfer) begin
      full_nxt = 1'b1;
    end else if (frame_load) begin
      full_nxt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      bclk         <= 1'b0;
      bit_cnt      <= BIT_MAX;
      lrclk        <= 1'b0;
      shift_reg    <= '0;
      // NOTE: the data registers are reset too, because a held sample must be
      // discarded and the hold-on-underrun fill word must start at 0.
      frame_word   <= '0;
      hold_reg     <= '0;
      full         <= 1'b0;
      sample_ready <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      div_cnt      <= wrap ? '0 : div_cnt + DIV_W'(1);
      full         <= full_nxt;
      sample_ready <= ~full_nxt;
      underrun     <= frame_load & ~full;

      if (wrap) begin
        bclk <= ~bclk;
      end

      if (transfer) begin
        hold_reg <= sample;
      end

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= lrclk_nxt;
        if (frame_load) begin
          frame_word <= load_word;
          shift_reg  <= slot_align(load_word);
        end else if (slot_load) begin
          shift_reg  <= slot_align(frame_word);
        end else begin
          shift_reg  <= shift_reg << 1;
        end
      end
    end
  end

  assign sdata = shift_reg[SLOT_BITS-1];

endmodule

// File: tb/tb_i2s_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_transmitter
//
// Directed bench for i2s_transmitter with BCLK_HALF=2, SLOT_BITS=16,
// SAMPLE_WIDTH=16. Outputs are sampled on the falling clk edge; inputs are
// driven there as well. Frame bits are collected one per BCLK fall, first bit
// into the MSB of a 32-bit word, so a duplicated sample S reads as {S, S}.
// Define I2S_TX_UNDERRUN_HOLD_EN for both RTL and bench to test the hold build.
// -----------------------------------------------------------------------------
module tb_i2s_transmitter;

  localparam int SW = 16;
  localparam int SB = 16;
  localparam int BH = 2;

  // lrclk high for frame bits 15..30, recorded first-bit-in-MSB.
  localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam logic [31:0] UNDERRUN_FRAME = 32'h7FFF_7FFF;
`else
  localparam logic [31:0] UNDERRUN_FRAME = 32'h0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;

  i2s_transmitter #(
    .SAMPLE_WIDTH (SW),
    .SLOT_BITS    (SB),
    .BCLK_HALF    (BH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_assert  = 0;
  int n_fail    = 0;
  int under_cnt = 0;
  int edge_cnt;
  int acc_cnt   = 0;
  bit bp        = 1'b0;

  // Counts underrun pulses over the whole run.
  always @(negedge clk) begin
    if (underrun === 1'b1) under_cnt <= under_cnt + 1;
  end

  // clk edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the falling-edge sample point right after the next BCLK fall.
  // In backpressure mode, the sample value advances after every accepted one.
  task automatic next_fall;
    logic prev;
    logic pend;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4 * BH + 4 && !found; i++) begin
      prev = bclk;
      pend = bp && sample_valid && sample_ready;
      @(negedge clk);
      if (pend) begin
        acc_cnt++;
        sample = sample + 1'b1;
      end
      if (prev === 1'b1 && bclk === 1'b0) found = 1'b1;
    end
    check("bclk_fall_seen", {31'b0, found}, 32'd1);
  endtask

  // Collect n frame bits: data, word select, ready; plus edge number and
  // underrun level at the first bit.
  task automatic cap(input int n, output logic [31:0] d, output logic [31:0] lr,
                     output logic [31:0] rd, output int e0, output logic u0);
    d = '0; lr = '0; rd = '0; e0 = -1; u0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      next_fall();
      d  = {d[30:0], sdata};
      lr = {lr[30:0], lrclk};
      rd = {rd[30:0], sample_ready};
      if (i == 0) begin
        e0 = edge_cnt;
        u0 = underrun;
      end
    end
  endtask

  task automatic send(input logic [SW-1:0] v, input string tag);
    for (int i = 0; i < 300 && sample_ready !== 1'b1; i++) @(negedge clk);
    check({tag, "_ready_before"}, {31'b0, sample_ready}, 32'd1);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check({tag, "_ready_after"}, {31'b0, sample_ready}, 32'd0);
  endtask

  logic [31:0] d, lr, rd, expw;
  int          e0, ub, ab;
  logic        u0;

  initial begin
    rst_n        = 1'b1;
    sample       = '0;
    sample_valid = 1'b0;
    #2 rst_n = 1'b0;

    // ---- Reset ----
    repeat (5) @(negedge clk);
    check("reset_outputs", {27'b0, bclk, lrclk, sdata, sample_ready, underrun}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_edge1", {31'b0, sample_ready}, 32'd1);
    check("bclk_edge1", {31'b0, bclk}, 32'd0);

    // ---- Single frame: 0xA5C3 accepted at edge 2, before the first fall ----
    sample       = 16'hA5C3;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ready_after_xfer", {31'b0, sample_ready}, 32'd0);
    check("bclk_edge2", {31'b0, bclk}, 32'd1);
    ub = under_cnt;
    cap(32, d, lr, rd, e0, u0);
    check("first_fall_edge", e0, 32'd4);
    check("f1_data", d, 32'hA5C3_A5C3);
    check("f1_lrclk", lr, LR_PATTERN);
    check("f1_underrun", under_cnt - ub, 32'd0);

    // ---- 0x7FFF, then nothing: next frame underruns ----
    send(16'h7FFF, "s7fff");
    ub = under_cnt;
    cap(32, d, lr, rd, e0, u0);
    check("f2_data", d, 32'h7FFF_7FFF);
    check("f2_underrun", under_cnt - ub, 32'd0);

    ub = under_cnt;
    cap(32, d, lr, rd, e0, u0);
    check("f3_underrun_at_load", {31'b0, u0}, 32'd1);
    check("f3_data", d, UNDERRUN_FRAME);
    check("f3_lrclk", lr, LR_PATTERN);
    check("f3_underrun_count", under_cnt - ub, 32'd1);

    // ---- Backpressure: valid held high with an incrementing value ----
    bp           = 1'b1;
    sample       = 16'h1000;
    sample_valid = 1'b1;
    ub = under_cnt;
    cap(32, d, lr, rd, e0, u0);
    check("bp_f4_data", d, 32'h1000_1000);
    ab = acc_cnt;
    cap(32, d, lr, rd, e0, u0);
    check("bp_f5_data", d, 32'h1001_1001);
    check("bp_f5_ready", rd, 32'h8000_0000);
    check("bp_f5_accepts", acc_cnt - ab, 32'd1);
    ab = acc_cnt;
    cap(32, d, lr, rd, e0, u0);
    check("bp_f6_data", d, 32'h1002_1002);
    check("bp_f6_ready", rd, 32'h8000_0000);
    check("bp_f6_accepts", acc_cnt - ab, 32'd1);
    check("bp_underrun", under_cnt - ub, 32'd0);
    bp           = 1'b0;
    sample_valid = 1'b0;

    // ---- Reset mid-frame at right bit 7; 0x1003 is in flight ----
    cap(1, d, lr, rd, e0, u0);
    check("f7_bit0", d, 32'd0);
    send(16'hBEEF, "sbeef");
    cap(23, d, lr, rd, e0, u0);
    expw = 32'h1003_1003;
    check("f7_bits1_23", d[22:0], {9'b0, expw[30:8]});
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {27'b0, bclk, lrclk, sdata, sample_ready, underrun}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ub = under_cnt;
    cap(32, d, lr, rd, e0, u0);
    check("restart_first_fall", e0, 32'd4);
    check("restart_data", d, 32'd0);
    check("restart_lrclk", lr, LR_PATTERN);
    check("restart_underrun", under_cnt - ub, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serializes processed 16-bit samples from the effects pipeline output onto a standard I2S link toward the codec DAC. It is the transmit end of the audio path; the codec-side receiver feeds the pipeline input. The block generates BCLK and LRCLK from the system clock and buffers one sample in a holding register behind a valid/ready handshake. Each sample is sent mono, duplicated into the left and right slots of one frame.

## Interface
- SAMPLE_WIDTH, 16: width of `sample`, in bits.
- SLOT_BITS, 16: BCLK periods per channel slot. Must be ≥ SAMPLE_WIDTH.
- BCLK_HALF, 8: `clk` cycles per BCLK half-period. Must be ≥ 2.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- sample  input  SAMPLE_WIDTH  two's-complement sample, for example `out_sample` of the effects pipeline.
- sample_valid  input  1  `sample` is valid this cycle.
- sample_ready  output  1  holding register is empty; registered.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  I2S word select: 0 selects the left slot, 1 selects the right slot.
- sdata  output  1  I2S serial data.
- underrun  output  1  one-`clk` pulse when a frame starts with no sample held.

## Operation
- **Divider.**
  - `div_cnt` counts 0..BCLK_HALF-1.
  - At the wrap cycle, `bclk` toggles.
  - A wrap that drives `bclk` from 1 to 0 is a *fall event*. All data and word-select updates happen only on fall events.
- **Bit counter.**
  - `bit_cnt` counts 0..2·SLOT_BITS-1 and advances on each fall event, wrapping back to 0.
  - Reset value is 2·SLOT_BITS-1, so the first fall event is frame bit 0.
- **Word select (I2S standard).**
  - `lrclk` = 1 when the current `bit_cnt` is in SLOT_BITS-1 .. 2·SLOT_BITS-2.
  - Otherwise `lrclk` = 0.
  - Effect: `lrclk` changes one BCLK before the MSB of each slot.
- **Frame load (fall event with `bit_cnt` = 0).**
  - If the holding register is full: copy it to `frame_word` and mark the register empty.
  - If the holding register is empty: assert `underrun` for that cycle and use the fill word (see Configuration).
- **Shift register.**
  - Loaded with `frame_word` at `bit_cnt` = 0 and again at `bit_cnt` = SLOT_BITS.
  - `sdata` drives the MSB of the shift register; the register shifts left on each fall event.
  - Bits beyond SAMPLE_WIDTH within a slot are driven as 0 (zero padding after the LSB).
- **Handshake.**
  - A transfer occurs on a cycle where `sample_valid` and `sample_ready` are both 1. `sample` is captured and the holding register becomes full.
  - `sample_ready` is the registered inverse of the full flag, so it deasserts the cycle after a transfer.
  - A frame load while empty that coincides with a transfer: `underrun` fires, and the new sample stays held for the next frame.
  - A frame load while full that coincides with `sample_valid`: no transfer occurs, because `sample_ready` was 0.
- **Reset (asynchronous, any time, including mid-frame).**
  - Reset values: `bclk` = 0, `lrclk` = 0, `sdata` = 0, `sample_ready` = 0, `underrun` = 0.
  - The held sample is discarded, `frame_word` = 0, and all counters return to their reset values.
  - `sample_ready` rises on the first `clk` edge after `rst_n` deasserts.

## Timing
- BCLK period = 2·BCLK_HALF `clk` cycles.
- Frame = 2·SLOT_BITS BCLK periods.
- After reset release, the first fall event occurs at `clk` edge 2·BCLK_HALF.
- `sdata` and `lrclk` change only together with a 1→0 transition of `bclk`. They are therefore stable for BCLK_HALF cycles around every rising edge, where the codec samples.
- Latency: a sample accepted before the fall event at `bit_cnt` = 0 appears on `sdata` MSB-first starting at that fall event.
- Throughput: at most one sample per frame.

## Configuration
- Macro `I2S_TX_UNDERRUN_HOLD_EN`.
- **Defined:** the underrun fill word is the previous `frame_word` (last sample repeats). After reset, the previous word is 0.
- **Undefined:** the underrun fill word is 0 (silence).
- `underrun` pulses identically in both builds.

## Test plan
Parameters for all tests unless stated: BCLK_HALF=2, SLOT_BITS=16, SAMPLE_WIDTH=16.
- **Reset:** hold `rst_n`=0 for 5 cycles, then release. All outputs are 0 during reset; `sample_ready`=1 on the 1st edge after release; the first `bclk` fall is at edge 4.
- **Single frame:** transfer 0xA5C3 before the first fall. `sdata` shows 1010010111000011 in the left slot and the same pattern in the right slot. `lrclk` rises at left bit 15, falls at right bit 15, and `underrun` never asserts.
- **Underrun, no-hold build:** send 0x7FFF in frame 1 and nothing afterward. Frame 2 is all zeros and `underrun` pulses exactly once, at the frame-2 load.
- **Underrun, hold build:** same stimulus with `I2S_TX_UNDERRUN_HOLD_EN` defined. Frame 2 repeats 0x7FFF in both slots and `underrun` still pulses once.
- **Backpressure:** hold `sample_valid`=1 with an incrementing value. Exactly one sample is accepted per frame; `sample_ready` is low from the cycle after acceptance until the next frame load; the sequence on `sdata` has no gaps and no duplicates.
- **Reset mid-frame:** assert `rst_n`=0 at right bit 7. Outputs clear immediately; after release, framing restarts at left bit 0 and the sample held before reset is not transmitted.
